llc_snoop_responder: RTL and testbench
======================================

# llc_snoop_responder

Bus-side snoop responder for the last-level cache model. It keeps a shadow tag/MESI directory that the local cache updates on fills and state changes. It accepts snooped bus operations issued by other caches, answers each with HIT / HITM / NOHIT, and applies the MESI downgrade or invalidate. On HITM it issues a line writeback over a valid/ready handshake. It is the responder end of the bus protocol whose initiator is the cache controller.

## Interface
- ADDR_SIZE, 32, bus address width
- OFFSET_SIZE, 6, byte-offset bits (64 B lines)
- INDEX_SIZE, 4, set-index bits (NUM_SETS = 2**INDEX_SIZE)
- N_WAY, 4, associativity; way field is $clog2(N_WAY) bits
- TAG_SIZE, derived, ADDR_SIZE-INDEX_SIZE-OFFSET_SIZE

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- snp_valid  in  1  snoop request present
- snp_ready  out  1  snoop accepted when snp_valid&&snp_ready
- snp_op  in  2  0=READ, 1=WRITE, 2=RWIM, 3=INVALIDATE
- snp_addr  in  ADDR_SIZE  snooped address
- rsp_valid  out  1  one-cycle pulse, result valid
- rsp_result  out  2  0=NOHIT, 1=HIT, 2=HITM
- wb_valid  out  1  writeback request, held until wb_ready
- wb_ready  in  1  writeback consumer ready
- wb_addr  out  ADDR_SIZE  line address, offset bits zero
- upd_valid  in  1  local directory write
- upd_addr  in  ADDR_SIZE  address giving set and tag
- upd_way  in  $clog2(N_WAY)  way to write
- upd_mesi  in  2  0=I, 1=S, 2=E, 3=M
- proto_err  out  1  sticky protocol-violation flag
- hit_count, hitm_count  out  16  statistics (see Configuration)

## Operation
- The directory holds NUM_SETS x N_WAY entries of {tag, mesi}. A line matches when mesi!=I and its tag equals the address tag.
- FSM states: IDLE, LOOKUP, RESPOND, WRITEBACK.
- IDLE: snp_ready=1. On accept, latch op, set and tag, then go to LOOKUP.
- LOOKUP: compare all ways and register the hit way and its old state, then go to RESPOND. If more than one way matches, use the lowest way and set proto_err.
- RESPOND: pulse rsp_valid and write the new state on the same edge.
  - If the result is HITM, go to WRITEBACK. Otherwise go to IDLE.
- Transitions by op:
  - READ: M→S HITM; E→S HIT; S→S HIT; miss NOHIT.
  - RWIM: M→I HITM; E/S→I HIT; miss NOHIT.
  - INVALIDATE: S→I HIT; miss NOHIT. On E or M: NOHIT, no state change, proto_err set.
  - WRITE: always NOHIT, no change. On M: proto_err set.
- WRITEBACK: wb_valid=1 with wb_addr={tag,set,0} until the cycle wb_ready=1, then go to IDLE.
- Update port:
  - Accepted in every state; writes {tag, upd_mesi} to [set][upd_way] at the edge.
  - If it targets the same set/way as a RESPOND state write on the same edge, the update wins and the snoop write is dropped.
  - LOOKUP uses the directory contents as of that cycle.

## Timing
- Reset values: snp_ready=0, rsp_valid=0, rsp_result=0, wb_valid=0, wb_addr=0, proto_err=0, counters=0. Every entry is set to mesi=I, tag=0. FSM goes to IDLE.
- snp_ready=1 from the first cycle after rst deasserts, while in IDLE.
- Latency: accept edge at cycle T; rsp_valid high during cycle T+2. The earliest wb_valid is cycle T+3.
- Throughput: one snoop per 3 cycles minimum without writeback, plus writeback stall cycles.
- rst asserted in any state aborts the operation: no rsp_valid, wb_valid drops, directory cleared on that edge.
- wb_valid and wb_addr stay stable while wb_ready=0.

## Configuration
- SNOOP_STATS_EN defined:
  - hit_count increments on each rsp_valid with HIT.
  - hitm_count increments on each rsp_valid with HITM.
  - Both are 16-bit, saturate at 0xFFFF and clear on rst.
- SNOOP_STATS_EN undefined: both outputs are tied to 0 and no counter logic is present.

## Test plan
- Reset then idle: all outputs 0 during rst. snp_ready=1 one cycle after. READ 0x0000_1040 → NOHIT at T+2, no wb_valid.
- upd M at 0x0000_1040 way 2, then READ 0x0000_1050 → HITM at T+2, wb_valid with wb_addr=0x0000_1040. Hold wb_ready=0 for 3 cycles: wb_valid stays high. Entry is then S.
- upd E at 0x00AB_0080, then RWIM → HIT, entry becomes I. A repeat READ → NOHIT.
- upd E, then INVALIDATE same address → NOHIT, proto_err=1, entry remains E.
- Snoop READ on an S line while upd_valid writes M to the same set/way on the RESPOND edge → rsp HIT, final state M.
- With SNOOP_STATS_EN: 2 HIT and 1 HITM snoops → hit_count=2, hitm_count=1. Without the macro, both counters read 0.

Source files
------------

// File: rtl/llc_snoop_responder.sv
// -----------------------------------------------------------------------------
// llc_snoop_responder
// Bus-side snoop responder for the last-level cache model. Keeps a shadow
// tag/MESI directory written by the local cache through the update port,
// answers snooped bus operations with HIT / HITM / NOHIT, applies the MESI
// downgrade or invalidate, and on HITM issues a line writeback over a
// valid/ready handshake.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_snp_valid/o_snp_ready snoop request handshake
//   i_snp_op, i_snp_addr    0=READ 1=WRITE 2=RWIM 3=INVALIDATE, address
//   o_rsp_valid/o_rsp_result one-cycle result pulse, 0=NOHIT 1=HIT 2=HITM
//   o_wb_valid/i_wb_ready   writeback handshake, o_wb_addr line address
//   i_upd_*                 local directory write (set/tag, way, MESI)
//   o_proto_err             sticky protocol-violation flag
//   o_hit_count/o_hitm_count statistics counters
//
// Optional feature: define SNOOP_STATS_EN to build the saturating HIT/HITM
// counters; otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module llc_snoop_responder #(
    parameter int ADDR_SIZE   = 32,
    parameter int OFFSET_SIZE = 6,
    parameter int INDEX_SIZE  = 4,
    parameter int N_WAY       = 4,
    parameter int TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE,
    parameter int WAY_W       = $clog2(N_WAY)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_snp_valid,
    output logic                 o_snp_ready,
    input  logic [1:0]           i_snp_op,
    input  logic [ADDR_SIZE-1:0] i_snp_addr,
    output logic                 o_rsp_valid,
    output logic [1:0]           o_rsp_result,
    output logic                 o_wb_valid,
    input  logic                 i_wb_ready,
    output logic [ADDR_SIZE-1:0] o_wb_addr,
    input  logic                 i_upd_valid,
    input  logic [ADDR_SIZE-1:0] i_upd_addr,
    input  logic [WAY_W-1:0]     i_upd_way,
    input  logic [1:0]           i_upd_mesi,
    output logic                 o_proto_err,
    output logic [15:0]          o_hit_count,
    output logic [15:0]          o_hitm_count
);
    localparam int NUM_SETS = 1 << INDEX_SIZE;

    localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
    localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_RWIM = 2'd2, OP_INV = 2'd3;
    localparam logic [1:0] RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_RESPOND, ST_WRITEBACK} state_t;

    state_t                r_state;
    logic                  r_snp_ready;
    logic                  r_rsp_valid;
    logic [1:0]            r_rsp_result;
    logic                  r_wb_valid;
    logic [ADDR_SIZE-1:0]  r_wb_addr;
    logic                  r_proto_err;
    logic [1:0]            r_op;
    logic [INDEX_SIZE-1:0] r_set;
    logic [TAG_SIZE-1:0]   r_tag;
    logic [WAY_W-1:0]      r_hit_way;
    logic [1:0]            r_new_mesi;
    logic                  r_wr_en;

    logic [TAG_SIZE-1:0]   r_dir_tag  [NUM_SETS][N_WAY];
    logic [1:0]            r_dir_mesi [NUM_SETS][N_WAY];

    logic                  w_hit;
    logic                  w_multi;
    logic [WAY_W-1:0]      w_hit_way;
    logic [1:0]            w_old_mesi;
    logic [1:0]            w_result;
    logic [1:0]            w_new_mesi;
    logic                  w_wr_en;
    logic                  w_err;
    logic                  w_unused_offset;

    wire [INDEX_SIZE-1:0] w_snp_set = i_snp_addr[OFFSET_SIZE +: INDEX_SIZE];
    wire [TAG_SIZE-1:0]   w_snp_tag = i_snp_addr[ADDR_SIZE-1 -: TAG_SIZE];
    wire [INDEX_SIZE-1:0] w_upd_set = i_upd_addr[OFFSET_SIZE +: INDEX_SIZE];
    wire [TAG_SIZE-1:0]   w_upd_tag = i_upd_addr[ADDR_SIZE-1 -: TAG_SIZE];

    // Byte-offset bits carry no meaning for a line-granular directory.
    assign w_unused_offset = ^{i_snp_addr[OFFSET_SIZE-1:0], i_upd_addr[OFFSET_SIZE-1:0]};

    // Way compare for the latched set/tag; scanning downward leaves the lowest matching way.
    always_comb begin
        w_hit      = 1'b0;
        w_multi    = 1'b0;
        w_hit_way  = {WAY_W{1'b0}};
        w_old_mesi = MESI_I;
        for (int w = N_WAY - 1; w >= 0; w--) begin
            if (r_dir_mesi[r_set][w] != MESI_I && r_dir_tag[r_set][w] == r_tag) begin
                w_multi    = w_multi | w_hit;
                w_hit      = 1'b1;
                w_hit_way  = WAY_W'(w);
                w_old_mesi = r_dir_mesi[r_set][w];
            end else begin
                w_multi = w_multi;
            end
        end
    end

    // MESI response/transition table; a miss presents as old state I.
    always_comb begin
        w_result   = RES_NOHIT;
        w_new_mesi = w_old_mesi;
        w_wr_en    = 1'b0;
        w_err      = w_multi;
        case (r_op)
            OP_READ: begin
                case (w_old_mesi)
                    MESI_M:          begin w_result = RES_HITM; w_new_mesi = MESI_S; w_wr_en = 1'b1; end
                    MESI_E, MESI_S:  begin w_result = RES_HIT;  w_new_mesi = MESI_S; w_wr_en = 1'b1; end
                    default:         w_wr_en = 1'b0;
                endcase
            end
            OP_WRITE: begin
                case (w_old_mesi)
                    MESI_M:  w_err = 1'b1;
                    default: w_wr_en = 1'b0;
                endcase
            end
            OP_RWIM: begin
                case (w_old_mesi)
                    MESI_M:          begin w_result = RES_HITM; w_new_mesi = MESI_I; w_wr_en = 1'b1; end
                    MESI_E, MESI_S:  begin w_result = RES_HIT;  w_new_mesi = MESI_I; w_wr_en = 1'b1; end
                    default:         w_wr_en = 1'b0;
                endcase
            end
            OP_INV: begin
                case (w_old_mesi)
                    MESI_S:          begin w_result = RES_HIT; w_new_mesi = MESI_I; w_wr_en = 1'b1; end
                    // Another cache invalidating a line we own exclusively is illegal.
                    MESI_E, MESI_M:  w_err = 1'b1;
                    default:         w_wr_en = 1'b0;
                endcase
            end
            default: w_wr_en = 1'b0;
        endcase
    end

    // Snoop FSM with registered handshake, response and writeback outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_snp_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= RES_NOHIT;
            r_wb_valid   <= 1'b0;
            r_wb_addr    <= {ADDR_SIZE{1'b0}};
            r_proto_err  <= 1'b0;
            r_op         <= OP_READ;
            r_set        <= {INDEX_SIZE{1'b0}};
            r_tag        <= {TAG_SIZE{1'b0}};
            r_hit_way    <= {WAY_W{1'b0}};
            r_new_mesi   <= MESI_I;
            r_wr_en      <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_snp_valid && r_snp_ready) begin
                        r_op        <= i_snp_op;
                        r_set       <= w_snp_set;
                        r_tag       <= w_snp_tag;
                        r_snp_ready <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end else begin
                        r_snp_ready <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= w_result;
                    r_hit_way    <= w_hit_way;
                    r_new_mesi   <= w_new_mesi;
                    r_wr_en      <= w_wr_en;
                    r_proto_err  <= r_proto_err | w_err;
                    r_state      <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    if (r_rsp_result == RES_HITM) begin
                        r_wb_valid <= 1'b1;
                        r_wb_addr  <= {r_tag, r_set, {OFFSET_SIZE{1'b0}}};
                        r_state    <= ST_WRITEBACK;
                    end else begin
                        r_snp_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WRITEBACK: begin
                    if (i_wb_ready) begin
                        r_wb_valid  <= 1'b0;
                        r_snp_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wb_valid <= 1'b1;
                    end
                end
                default: begin
                    r_snp_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    // Directory storage; the update port is written last so it wins a same-entry collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < N_WAY; w++) begin
                    r_dir_tag[s][w]  <= {TAG_SIZE{1'b0}};
                    r_dir_mesi[s][w] <= MESI_I;
                end
            end
        end else begin
            if (r_state == ST_RESPOND && r_wr_en) begin
                r_dir_mesi[r_set][r_hit_way] <= r_new_mesi;
            end
            if (i_upd_valid) begin
                r_dir_tag[w_upd_set][i_upd_way]  <= w_upd_tag;
                r_dir_mesi[w_upd_set][i_upd_way] <= i_upd_mesi;
            end
        end
    end

`ifdef SNOOP_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_hitm_count;

    // Saturating response statistics, counted on the response pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hit_count  <= 16'h0000;
            r_hitm_count <= 16'h0000;
        end else begin
            if (r_rsp_valid && r_rsp_result == RES_HIT && r_hit_count != 16'hFFFF) begin
                r_hit_count <= r_hit_count + 16'h0001;
            end
            if (r_rsp_valid && r_rsp_result == RES_HITM && r_hitm_count != 16'hFFFF) begin
                r_hitm_count <= r_hitm_count + 16'h0001;
            end
        end
    end

    assign o_hit_count  = r_hit_count;
    assign o_hitm_count = r_hitm_count;
`else
    assign o_hit_count  = 16'h0000;
    assign o_hitm_count = 16'h0000;
`endif

    assign o_snp_ready  = r_snp_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_rsp_result;
    assign o_wb_valid   = r_wb_valid;
    assign o_wb_addr    = r_wb_addr;
    assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_llc_snoop_responder.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for llc_snoop_responder. Inputs are driven
// after the rising edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_llc_snoop_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        snp_valid = 1'b0;
    logic        snp_ready;
    logic [1:0]  snp_op = 2'd0;
    logic [31:0] snp_addr = 32'h0;
    logic        rsp_valid;
    logic [1:0]  rsp_result;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [31:0] wb_addr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_addr = 32'h0;
    logic [1:0]  upd_way = 2'd0;
    logic [1:0]  upd_mesi = 2'd0;
    logic        proto_err;
    logic [15:0] hit_count;
    logic [15:0] hitm_count;

    int n_chk = 0;
    int n_bad = 0;

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, RWIM = 2'd2, INV = 2'd3;
    localparam logic [1:0] NOHIT = 2'd0, HIT = 2'd1, HITM = 2'd2;
    localparam logic [1:0] M_I = 2'd0, M_S = 2'd1, M_E = 2'd2, M_M = 2'd3;

    llc_snoop_responder dut (
        .i_clk(clk), .i_rst(rst),
        .i_snp_valid(snp_valid), .o_snp_ready(snp_ready),
        .i_snp_op(snp_op), .i_snp_addr(snp_addr),
        .o_rsp_valid(rsp_valid), .o_rsp_result(rsp_result),
        .o_wb_valid(wb_valid), .i_wb_ready(wb_ready), .o_wb_addr(wb_addr),
        .i_upd_valid(upd_valid), .i_upd_addr(upd_addr),
        .i_upd_way(upd_way), .i_upd_mesi(upd_mesi),
        .o_proto_err(proto_err),
        .o_hit_count(hit_count), .o_hitm_count(hitm_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Single-cycle directory write, leaves us at the next falling edge.
    task automatic upd(input logic [31:0] a, input logic [1:0] way, input logic [1:0] mesi);
        upd_valid = 1'b1; upd_addr = a; upd_way = way; upd_mesi = mesi;
        @(posedge clk); #1 upd_valid = 1'b0;
        @(negedge clk);
    endtask

    // Issue a snoop from a falling edge; returns at the falling edge of the response cycle.
    task automatic snoop(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [1:0] exp_res);
        chk({tag, "_ready"}, {31'd0, snp_ready}, 32'd1);
        snp_valid = 1'b1; snp_op = op; snp_addr = a;
        @(posedge clk); #1 snp_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_result"}, {30'd0, rsp_result}, {30'd0, exp_res});
    endtask

    // Finish a non-HITM snoop: back in idle one cycle later, no writeback.
    task automatic idle_after(input string tag);
        @(negedge clk);
        chk({tag, "_nowb"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    // Writeback seen at T+3, held for 'hold' cycles of wb_ready=0, then drained.
    task automatic drain(input string tag, input logic [31:0] a, input int hold);
        @(negedge clk);
        chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_wba"}, wb_addr, a);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, {31'd0, wb_valid}, 32'd1);
            chk({tag, "_hold_a"}, wb_addr, a);
        end
        wb_ready = 1'b1;
        @(posedge clk); #1 wb_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_wbdone"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, snp_ready}, 32'd1);
    endtask

    initial begin
        // Reset: every output low while rst is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, snp_ready}, 32'd0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_result}, 32'd0);
        chk("rst_wb", {31'd0, wb_valid}, 32'd0);
        chk("rst_wbaddr", wb_addr, 32'd0);
        chk("rst_err", {31'd0, proto_err}, 32'd0);
        chk("rst_cnt", {hit_count, hitm_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, snp_ready}, 32'd1);

        // Empty directory: miss.
        snoop("miss", RD, 32'h0000_1040, NOHIT);
        idle_after("miss");

        // Modified line in set 1 way 2, snooped at another offset of the same line.
        upd(32'h0000_1040, 2'd2, M_M);
        snoop("rd_m", RD, 32'h0000_1050, HITM);
        drain("rd_m", 32'h0000_1040, 3);
        snoop("rd_s", RD, 32'h0000_1040, HIT);
        idle_after("rd_s");

        // RWIM on an exclusive line invalidates it.
        upd(32'h00AB_0080, 2'd0, M_E);
        snoop("rwim_e", RWIM, 32'h00AB_0080, HIT);
        idle_after("rwim_e");
        snoop("rwim_gone", RD, 32'h00AB_0080, NOHIT);
        idle_after("rwim_gone");
        chk("err_clear", {31'd0, proto_err}, 32'd0);

        // INVALIDATE on an E line is illegal: NOHIT, sticky error, line kept.
        upd(32'h0000_2000, 2'd1, M_E);
        snoop("inv_e", INV, 32'h0000_2000, NOHIT);
        idle_after("inv_e");
        chk("err_set", {31'd0, proto_err}, 32'd1);
        snoop("inv_kept", RD, 32'h0000_2000, HIT);
        idle_after("inv_kept");

        // Plain WRITE snoop never hits.
        snoop("write", WR, 32'h0000_1040, NOHIT);
        idle_after("write");

        // READ on an S line while the local cache writes M to that entry on the response edge.
        upd(32'h0000_3000, 2'd3, M_S);
        snoop("race", RD, 32'h0000_3000, HIT);
        upd_valid = 1'b1; upd_addr = 32'h0000_3000; upd_way = 2'd3; upd_mesi = M_M;
        @(posedge clk); #1 upd_valid = 1'b0;
        @(negedge clk);
        chk("race_nowb", {31'd0, wb_valid}, 32'd0);
        snoop("race_m", RD, 32'h0000_3000, HITM);
        drain("race_m", 32'h0000_3000, 0);

        // HIT responses: rd_s, rwim_e, inv_kept, race. HITM: rd_m, race_m.
`ifdef SNOOP_STATS_EN
        chk("hit_count", {16'd0, hit_count}, 32'd4);
        chk("hitm_count", {16'd0, hitm_count}, 32'd2);
`else
        chk("hit_count", {16'd0, hit_count}, 32'd0);
        chk("hitm_count", {16'd0, hitm_count}, 32'd0);
`endif

        // Reset in the middle of a HITM snoop aborts it and clears everything.
        snp_valid = 1'b1; snp_op = RD; snp_addr = 32'h0000_3000;
        @(posedge clk); #1 snp_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("abort_wb", {31'd0, wb_valid}, 32'd0);
        chk("abort_err", {31'd0, proto_err}, 32'd0);
        chk("abort_cnt", {hit_count, hitm_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        snoop("cleared", RD, 32'h0000_3000, NOHIT);
        idle_after("cleared");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
